// File: rtl/maxi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | maxi_pkg : shared widths, response codes and FSM encodings       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package maxi_pkg;

   localparam int ID_W   = 12;
   localparam int LEN_W  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [0:0] rd_state_t;
   typedef logic [1:0] wr_state_t;

   localparam rd_state_t RIDLE  = 1'b0;
   localparam rd_state_t RBURST = 1'b1;

   localparam wr_state_t WIDLE = 2'd0;
   localparam wr_state_t WDATA = 2'd1;
   localparam wr_state_t WRESP = 2'd2;

   function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] mask);
      return |(addr & mask);
   endfunction

   // Burst index advance; NREG is a power of two so masking gives the wrap.
   function automatic logic [3:0] next_idx(input logic [3:0] idx, input int nreg);
      return (idx + 4'd1) & 4'(nreg - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/maxi_gp_reg_slave_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | maxi_gp_reg_slave_if : GP0 AR/AW/W/R/B channel bundle             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface maxi_gp_reg_slave_if;
   import maxi_pkg::*;

   logic              ar_ena;
   logic [ADDR_W-1:0] ar_addr;
   logic [ID_W-1:0]   ar_id;
   logic [LEN_W-1:0]  ar_len;
   logic              ar_rdy;

   logic              aw_ena;
   logic [ADDR_W-1:0] aw_addr;
   logic [ID_W-1:0]   aw_id;
   logic [LEN_W-1:0]  aw_len;
   logic              aw_rdy;

   logic              w_ena;
   logic [DATA_W-1:0] w_data;
   logic [ID_W-1:0]   w_id;
   logic              w_last;
   logic              w_rdy;

   logic              r_ena;
   logic [DATA_W-1:0] r_data;
   logic [ID_W-1:0]   r_id;
   logic              r_last;
   logic [1:0]        r_resp;
   logic              r_rdy;

   logic              b_ena;
   logic [ID_W-1:0]   b_id;
   logic [1:0]        b_resp;
   logic              b_rdy;

   modport master (
      output ar_ena, ar_addr, ar_id, ar_len, input ar_rdy,
      output aw_ena, aw_addr, aw_id, aw_len, input aw_rdy,
      output w_ena, w_data, w_id, w_last, input w_rdy,
      input  r_ena, r_data, r_id, r_last, r_resp, output r_rdy,
      input  b_ena, b_id, b_resp, output b_rdy
   );

   modport slave (
      input  ar_ena, ar_addr, ar_id, ar_len, output ar_rdy,
      input  aw_ena, aw_addr, aw_id, aw_len, output aw_rdy,
      input  w_ena, w_data, w_id, w_last, output w_rdy,
      output r_ena, r_data, r_id, r_last, r_resp, input r_rdy,
      output b_ena, b_id, b_resp, input b_rdy
   );

endinterface
`default_nettype wire

// File: rtl/maxi_gp_reg_slave_reg_file.sv
`default_nettype none
// +------------------------------------------------------------------+
// | maxi_reg_file : NREG x 32 registers, 1 write / 1 async read port, |
// | index 15 reads a free-running cycle counter. Rev 1.0              |
// +------------------------------------------------------------------+
module maxi_reg_file
   import maxi_pkg::*;
#(
   parameter int NREG = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [3:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        raddr,
   output logic [DATA_W-1:0] rdata,
   output logic              irq
);

   localparam int IDX_W = $clog2(NREG);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [DATA_W-1:0] cnt_q;
   logic [DATA_W-1:0] cnt_d;

   // Slot 15 belongs to the counter, so writes there are silently dropped.
   always_comb begin
      regs_d = regs_q;
      if (we && (int'(waddr) < NREG) && (waddr != 4'd15)) begin
         regs_d[waddr[IDX_W-1:0]] = wdata;
      end
      cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         cnt_q <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (raddr == 4'd15) begin
         rdata = cnt_q;
      end else if (int'(raddr) < NREG) begin
         rdata = regs_q[raddr[IDX_W-1:0]];
      end
   end

   assign irq = regs_q[1][0];

endmodule
`default_nettype wire

// File: rtl/maxi_gp_reg_slave.sv
`default_nettype none
// +------------------------------------------------------------------+
// | maxi_gp_reg_slave : GP0 burst slave over a 16 x 32 register file  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module maxi_gp_reg_slave
   import maxi_pkg::*;
#(
   parameter int                NREG      = 16,
   parameter logic [ADDR_W-1:0] BASE_MASK = 32'h0000_0FC0
) (
   input  logic                CLK,
   input  logic                nRST,
   maxi_gp_reg_slave_if.slave  bus,
   output logic                interrupt
);

   // Holds the address-ready outputs low until the first edge after reset.
   logic live_q, live_d;

   rd_state_t         rstate_q, rstate_d;
   logic [3:0]        ridx_q, ridx_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [LEN_W-1:0]  rcnt_q, rcnt_d;
   logic              rerr_q, rerr_d;

   wr_state_t         wstate_q, wstate_d;
   logic [3:0]        widx_q, widx_d;
   logic [ID_W-1:0]   wid_q, wid_d;
   logic [LEN_W-1:0]  wcnt_q, wcnt_d;
   logic              werr_q, werr_d;
   logic [1:0]        bresp_q, bresp_d;

   logic              ar_fire, r_fire;
   logic              aw_fire, w_fire, b_fire;
   logic              w_id_ok;
   logic              rf_we;
   logic [DATA_W-1:0] rf_rdata;

   assign live_d  = 1'b1;
   assign ar_fire = live_q && (rstate_q == RIDLE) && bus.ar_ena;
   assign r_fire  = (rstate_q == RBURST) && bus.r_rdy;
   assign aw_fire = live_q && (wstate_q == WIDLE) && bus.aw_ena;
   assign w_fire  = (wstate_q == WDATA) && bus.w_ena;
   assign b_fire  = (wstate_q == WRESP) && bus.b_rdy;
   assign w_id_ok = (bus.w_id == wid_q);
   assign rf_we   = w_fire && !werr_q && w_id_ok;

   always_comb begin
      rstate_d = rstate_q;
      ridx_d   = ridx_q;
      rid_d    = rid_q;
      rcnt_d   = rcnt_q;
      rerr_d   = rerr_q;
      case (rstate_q)
         RIDLE: begin
            if (ar_fire) begin
               rstate_d = RBURST;
               ridx_d   = bus.ar_addr[5:2];
               rid_d    = bus.ar_id;
               rcnt_d   = bus.ar_len;
               rerr_d   = addr_err(bus.ar_addr, BASE_MASK);
            end
         end
         RBURST: begin
            if (r_fire) begin
               ridx_d = next_idx(ridx_q, NREG);
               rcnt_d = rcnt_q - 1'b1;
               if (rcnt_q == '0) begin
                  rstate_d = RIDLE;
               end
            end
         end
         default: rstate_d = RIDLE;
      endcase
   end

   // The burst length is authoritative; a misplaced w_last only poisons the response.
   always_comb begin
      wstate_d = wstate_q;
      widx_d   = widx_q;
      wid_d    = wid_q;
      wcnt_d   = wcnt_q;
      werr_d   = werr_q;
      bresp_d  = bresp_q;
      case (wstate_q)
         WIDLE: begin
            if (aw_fire) begin
               wstate_d = WDATA;
               widx_d   = bus.aw_addr[5:2];
               wid_d    = bus.aw_id;
               wcnt_d   = bus.aw_len;
               werr_d   = addr_err(bus.aw_addr, BASE_MASK);
               bresp_d  = RESP_OKAY;
            end
         end
         WDATA: begin
            if (w_fire) begin
               if (!w_id_ok || (bus.w_last != (wcnt_q == '0))) begin
                  bresp_d = RESP_SLVERR;
               end
               widx_d = next_idx(widx_q, NREG);
               wcnt_d = wcnt_q - 1'b1;
               if (wcnt_q == '0) begin
                  wstate_d = WRESP;
               end
            end
         end
         WRESP: begin
            if (b_fire) begin
               wstate_d = WIDLE;
            end
         end
         default: wstate_d = WIDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         live_q   <= 1'b0;
         rstate_q <= RIDLE;
         ridx_q   <= '0;
         rid_q    <= '0;
         rcnt_q   <= '0;
         rerr_q   <= 1'b0;
         wstate_q <= WIDLE;
         widx_q   <= '0;
         wid_q    <= '0;
         wcnt_q   <= '0;
         werr_q   <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         live_q   <= live_d;
         rstate_q <= rstate_d;
         ridx_q   <= ridx_d;
         rid_q    <= rid_d;
         rcnt_q   <= rcnt_d;
         rerr_q   <= rerr_d;
         wstate_q <= wstate_d;
         widx_q   <= widx_d;
         wid_q    <= wid_d;
         wcnt_q   <= wcnt_d;
         werr_q   <= werr_d;
         bresp_q  <= bresp_d;
      end
   end

   maxi_reg_file #(
      .NREG (NREG)
   ) u_reg_file (
      .clk   (CLK),
      .rst_n (nRST),
      .we    (rf_we),
      .waddr (widx_q),
      .wdata (bus.w_data),
      .raddr (ridx_q),
      .rdata (rf_rdata),
      .irq   (interrupt)
   );

   assign bus.ar_rdy = live_q && (rstate_q == RIDLE);
   assign bus.aw_rdy = live_q && (wstate_q == WIDLE);
   assign bus.w_rdy  = (wstate_q == WDATA);

   assign bus.r_ena  = (rstate_q == RBURST);
   assign bus.r_id   = rid_q;
   assign bus.r_last = (rstate_q == RBURST) && (rcnt_q == '0);
   assign bus.r_data = ((rstate_q == RBURST) && !rerr_q) ? rf_rdata : '0;
   assign bus.r_resp = ((rstate_q == RBURST) && rerr_q) ? RESP_SLVERR : RESP_OKAY;

   assign bus.b_ena  = (wstate_q == WRESP);
   assign bus.b_id   = wid_q;
   assign bus.b_resp = (wstate_q != WRESP) ? RESP_OKAY
                     : (werr_q ? RESP_SLVERR : bresp_q);

endmodule
`default_nettype wire

// File: doc/maxi_gp_reg_slave.md
Name: maxi_gp_reg_slave

Overview:
- AXI3-lite-burst slave that consumes the GP0 master channels (AR/AW/W) produced by the PS7 wrapper and returns R/B responses to it.
- Backs a 16 x 32-bit register file.
  - Register 15 is a free-running read-only cycle counter.
  - Register 1 bit 0 drives the interrupt line.
- Sits directly downstream of the PS7 wrapper, in place of the simple test endpoint.

Parameters:
- NREG, 16, number of 32-bit registers (power of 2, max 16).
- BASE_MASK, 32'h00000FC0, address bits that must be zero for an in-range access.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- AR__ENA  in  1  read address valid; asserted only while AR__RDY is high.
- AR$addr  in  32  read byte address.
- AR$id  in  12  read transaction id.
- AR$len  in  4  read beats minus 1.
- AR__RDY  out  1  read address accept.
- AW__ENA  in  1  write address valid.
- AW$addr  in  32  write byte address.
- AW$id  in  12  write id.
- AW$len  in  4  write beats minus 1.
- AW__RDY  out  1  write address accept.
- W__ENA  in  1  write data valid.
- W$data  in  32  write data.
- W$id  in  12  write data id.
- W$last  in  1  final write beat.
- W__RDY  out  1  write data accept.
- R__ENA  out  1  read data valid.
- R$data  out  32  read data.
- R$id  out  12  read id.
- R$last  out  1  final read beat.
- R$resp  out  2  read response (00 OKAY, 10 SLVERR).
- R__RDY  in  1  read data accept.
- B__ENA  out  1  write response valid.
- B$id  out  12  write response id.
- B$resp  out  2  write response.
- B__RDY  in  1  write response accept.
- interrupt  out  1  level = reg[1][0].

Behaviour:
- Transfer rule: a beat transfers on a cycle where ENA && RDY. Outputs hold stable while ENA=1 && RDY=0.
- Reset (async, nRST=0): all registers and the counter go to 0; both FSMs go to IDLE.
  - Outputs during reset: AR__RDY=AW__RDY=W__RDY=0, R__ENA=B__ENA=0, R$data=0, R$resp=0, R$last=0, interrupt=0.
  - Reset mid-burst abandons the burst; no response is issued.
  - After nRST rises, AR__RDY and AW__RDY go high on the next CLK edge.
- Read FSM states: RIDLE, RBURST.
  - RIDLE: AR__RDY=1. An accepted AR latches addr[5:2], id, count=len, and err=|(addr & BASE_MASK); next state is RBURST.
  - RBURST: AR__RDY=0, R__ENA=1.
    - R$data = err ? 0 : reg[idx]. idx=15 returns the counter.
    - R$resp = err ? 10 : 00. R$last = (count==0).
    - On transfer: idx increments mod NREG (wraps 15 -> 0) and count decrements. A transfer with last set returns to RIDLE.
  - Latency: AR accepted on edge N gives first R__ENA in cycle N+1. Sustains 1 beat/cycle while R__RDY=1.
- Write FSM states: WIDLE, WDATA, WRESP.
  - WIDLE: AW__RDY=1, W__RDY=0. An accepted AW latches idx, id, count, and err as for reads; next state is WDATA. W beats arriving before AW are stalled (W__RDY=0).
  - WDATA: W__RDY=1. Each beat:
    - Writes reg[idx] only if !err and W$id==latched id and idx!=15. Writes to 15 are ignored but respond OKAY.
    - Any id mismatch, or W$last disagreeing with (count==0), sets a sticky bresp=10.
    - idx wraps mod NREG.
    - The burst ends on the beat where count==0, regardless of W$last, and moves to WRESP.
  - WRESP: B__ENA=1, B$id=latched id, B$resp=err ? 10 : sticky. Transfer returns to WIDLE.
  - Minimum latency: last W on edge N gives B__ENA in cycle N+1.
- Read and write paths are independent and run concurrently.
  - A read of a register written the same cycle returns the old value.
  - The new value is visible on the following beat.
- Counter: reg15 increments every cycle and wraps 32'hFFFFFFFF -> 0.
- interrupt is registered from reg[1][0] (it is reg[1] bit 0 itself, no extra latency beyond the write).

Decomposition:
- Shared package maxi_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - ID_W=12, LEN_W=4, DATA_W=32, ADDR_W=32;
  - read/write FSM state enums.
- Natural sub-module: maxi_reg_file (NREG x 32, one write port, one combinational read port, counter at index 15), instanced once.
- The two FSMs stay in the top.

Test Plan:
- Reset then single write/read:
  - Stimulus: AW addr=0x08 id=0x5 len=0, W data=0xDEADBEEF id=0x5 last=1.
  - Required: B id=0x5 resp=00.
  - Then AR addr=0x08 len=0 gives R data=0xDEADBEEF last=1 resp=00, first R__ENA one cycle after AR accept.
- Wrapping burst:
  - Stimulus: AW addr=0x38 len=3, data 1,2,3,4.
  - Required: reg14=1, reg15 unchanged counter, reg0=3, reg1=4. B resp=00.
  - Interrupt rises after the 4th beat (reg1[0]=0 -> wait: data 4 gives interrupt=0). Then a write of 1 to reg1 gives interrupt=1.
- Out-of-range and protocol errors:
  - AR addr=0x100 len=1 gives 2 beats data=0 resp=10.
  - AW id=0x3 followed by W id=0x4 gives no register change and B resp=10.
  - len=1 with W$last on beat 0 gives B resp=10, and the burst still ends after beat 1.
- Backpressure:
  - Stimulus: read len=2, R__RDY toggling 1,0,0,1,1.
  - Required: R$data and R$last held stable while stalled; exactly 3 transfers; AR__RDY=0 until the last transfer.
- Concurrency:
  - Stimulus: simultaneous AR and AW to reg 2 (old value 0x11, new value 0x22).
  - Required: a read beat coincident with the write returns 0x11; a subsequent read returns 0x22. B and R complete independently.
- Async reset mid-burst:
  - Stimulus: drop nRST during WDATA of a len=7 burst.
  - Required: outputs go to reset values immediately with no B response. After release, AW__RDY=1 and all registers=0.
